// File: rtl/rr_arb_mux.sv
// N-channel registered round-robin arbiter/mux with valid/ready on every channel.
// Optional RR_ARB_MUX_LOCK_EN adds in_lock so a channel can hold priority across a burst.
module rr_arb_mux #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SELW  = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [(2**SELW)-1:0]         in_valid,
  input  logic [(2**SELW)*WIDTH-1:0]   in_data,
`ifdef RR_ARB_MUX_LOCK_EN
  input  logic [(2**SELW)-1:0]         in_lock,
`endif
  output logic [(2**SELW)-1:0]         in_ready,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  output logic [SELW-1:0]              out_sel,
  input  logic                         out_ready
);

  localparam int unsigned N = 2**SELW;

  logic [WIDTH-1:0] chan_data [N];
  logic [SELW-1:0]  ptr_q, ptr_d;
  logic [SELW-1:0]  grant, cand;
  logic             gvalid, can_accept, in_xfer;
  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic [SELW-1:0]  sel_q;

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign chan_data[i] = in_data[i*WIDTH +: WIDTH];
  end

  // Scan from the farthest offset down so the nearest valid channel to ptr wins.
  always_comb begin
    grant  = '0;
    gvalid = 1'b0;
    cand   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = ptr_q + SELW'(k);
      if (in_valid[cand]) begin
        grant  = cand;
        gvalid = 1'b1;
      end
    end
  end

  assign can_accept = ~valid_q | out_ready;

  always_comb begin
    in_ready = '0;
    if (gvalid && can_accept && !reset) begin
      in_ready[grant] = 1'b1;
    end
  end

  assign in_xfer = |in_ready;

`ifdef RR_ARB_MUX_LOCK_EN
  assign ptr_d = in_lock[grant] ? grant : grant + 1'b1;
`else
  assign ptr_d = grant + 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else if (in_xfer) begin
      valid_q <= 1'b1;
      data_q  <= chan_data[grant];
      sel_q   <= grant;
      ptr_q   <= ptr_d;
    end else if (valid_q && out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_sel   = sel_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Self-checking bench for rr_arb_mux: directed vector table, lock/no-lock burst, random vs model.
module tb_rr_arb_mux;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned SELW  = 2;
  localparam int unsigned N     = 4;
`ifdef RR_ARB_MUX_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       cur_lock;
  logic [N-1:0]       in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_sel;
  logic               out_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_arb_mux #(.WIDTH(WIDTH), .SELW(SELW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
`ifdef RR_ARB_MUX_LOCK_EN
    .in_lock   (cur_lock),
`endif
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  // Reference model: output register contents and round-robin pointer as plain integers.
  bit          m_valid = 1'b0;
  logic [31:0] m_data  = '0;
  int          m_sel   = 0;
  int          m_ptr   = 0;

  function automatic int m_grant(input logic [N-1:0] v);
    for (int off = 0; off < N; off++) begin
      if (v[(m_ptr + off) % N]) return (m_ptr + off) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_ready();
    logic [N-1:0] r;
    int g;
    r = '0;
    g = m_grant(in_valid);
    if (g >= 0 && (!m_valid || out_ready) && !reset) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_update();
    int g;
    if (reset) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_sel   = 0;
      m_ptr   = 0;
    end else if (m_ready() != '0) begin
      g       = m_grant(in_valid);
      m_valid = 1'b1;
      m_data  = in_data[g*WIDTH +: WIDTH];
      m_sel   = g;
      m_ptr   = (LOCK_EN && cur_lock[g]) ? g : (g + 1) % N;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit rst, input logic [N-1:0] vld, input bit ordy,
                       input logic [N-1:0] lck);
    reset     = rst;
    in_valid  = vld;
    out_ready = ordy;
    cur_lock  = lck;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  typedef struct {
    bit           rst;
    logic [N-1:0] vld;
    bit           ordy;
    bit           chk_out;
    logic [N-1:0] ready;
    bit           ov;
    int           sel;
    logic [31:0]  data;
  } vec_t;

  vec_t tbl[20];
  int   lock_seq[4];

  initial begin
    // Expected values are the state before the edge on which the row's inputs are sampled.
    tbl[0]  = '{1'b1, 4'hF, 1'b1, 1'b0, 4'h0, 1'b0, 0, 32'h0};
    tbl[1]  = '{1'b1, 4'hF, 1'b1, 1'b1, 4'h0, 1'b0, 0, 32'h0};
    tbl[2]  = '{1'b0, 4'hF, 1'b1, 1'b1, 4'h1, 1'b0, 0, 32'h0};
    tbl[3]  = '{1'b0, 4'hF, 1'b1, 1'b1, 4'h2, 1'b1, 0, 32'hA0};
    tbl[4]  = '{1'b0, 4'hF, 1'b1, 1'b1, 4'h4, 1'b1, 1, 32'hA1};
    tbl[5]  = '{1'b0, 4'hF, 1'b1, 1'b1, 4'h8, 1'b1, 2, 32'hA2};
    tbl[6]  = '{1'b0, 4'hF, 1'b1, 1'b1, 4'h1, 1'b1, 3, 32'hA3};
    tbl[7]  = '{1'b0, 4'h0, 1'b1, 1'b1, 4'h0, 1'b1, 0, 32'hA0};
    tbl[8]  = '{1'b0, 4'h0, 1'b1, 1'b1, 4'h0, 1'b0, 0, 32'hA0};
    tbl[9]  = '{1'b0, 4'h4, 1'b1, 1'b1, 4'h4, 1'b0, 0, 32'hA0};
    tbl[10] = '{1'b0, 4'h5, 1'b1, 1'b1, 4'h1, 1'b1, 2, 32'hA2};
    tbl[11] = '{1'b0, 4'h5, 1'b1, 1'b1, 4'h4, 1'b1, 0, 32'hA0};
    tbl[12] = '{1'b0, 4'h2, 1'b0, 1'b1, 4'h0, 1'b1, 2, 32'hA2};
    tbl[13] = '{1'b0, 4'h2, 1'b0, 1'b1, 4'h0, 1'b1, 2, 32'hA2};
    tbl[14] = '{1'b0, 4'h2, 1'b0, 1'b1, 4'h0, 1'b1, 2, 32'hA2};
    tbl[15] = '{1'b0, 4'h2, 1'b1, 1'b1, 4'h2, 1'b1, 2, 32'hA2};
    tbl[16] = '{1'b0, 4'hF, 1'b0, 1'b1, 4'h0, 1'b1, 1, 32'hA1};
    tbl[17] = '{1'b1, 4'hF, 1'b0, 1'b1, 4'h0, 1'b1, 1, 32'hA1};
    tbl[18] = '{1'b0, 4'hF, 1'b1, 1'b1, 4'h1, 1'b0, 0, 32'h0};
    tbl[19] = '{1'b0, 4'h0, 1'b1, 1'b1, 4'h0, 1'b1, 0, 32'hA0};

    for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = 32'hA0 + i;

    for (int r = 0; r < 20; r++) begin
      drive(tbl[r].rst, tbl[r].vld, tbl[r].ordy, '0);
      #2;
      chk($sformatf("vec%0d in_ready", r), 32'(in_ready), 32'(tbl[r].ready));
      if (tbl[r].chk_out) begin
        chk($sformatf("vec%0d out_valid", r), 32'(out_valid), 32'(tbl[r].ov));
        chk($sformatf("vec%0d out_sel", r), 32'(out_sel), tbl[r].sel);
        chk($sformatf("vec%0d out_data", r), out_data, tbl[r].data);
      end
      tick();
    end

    // Burst on channel 2 with in_lock[2] = 1,1,0 while every channel stays valid.
`ifdef RR_ARB_MUX_LOCK_EN
    lock_seq = '{2, 2, 2, 3};
`else
    lock_seq = '{2, 3, 0, 1};
`endif
    drive(1'b1, 4'hF, 1'b1, '0);
    tick();
    drive(1'b0, 4'h2, 1'b1, '0);
    tick();
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 4'hF, 1'b1, (c < 2) ? 4'h4 : 4'h0);
      #2;
      chk($sformatf("lock%0d in_ready", c), 32'(in_ready), 32'(1) << lock_seq[c]);
      tick();
      #2;
      chk($sformatf("lock%0d out_sel", c), 32'(out_sel), lock_seq[c]);
      chk($sformatf("lock%0d out_valid", c), 32'(out_valid), 32'd1);
    end

    // Random traffic against the model.
    drive(1'b1, 4'h0, 1'b1, '0);
    tick();
    for (int t = 0; t < 1500; t++) begin
      drive($urandom_range(63) == 0, N'($urandom), $urandom_range(3) != 0, N'($urandom));
      for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = $urandom;
      #2;
      chk("rand in_ready", 32'(in_ready), 32'(m_ready()));
      chk("rand out_valid", 32'(out_valid), 32'(m_valid));
      chk("rand out_sel", 32'(out_sel), m_sel);
      chk("rand out_data", out_data, m_data);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised successor to the plain combinational 4:1 mux: an N-channel registered multiplexer with round-robin arbitration and a valid/ready handshake on every channel.
- Merges several requesters into a single downstream consumer, e.g. instruction-fetch and data-access paths sharing one memory port in the MIPS datapath.
- One-entry output register; one beat per cycle sustained throughput.

Parameters:
- WIDTH, 32, data width per channel in bits.
- SELW, 2, select width; channel count N = 2**SELW; legal 1..3 (N = 2..8).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  N  per-channel request; bit i = channel i.
- in_data  input  N*WIDTH  flattened data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  N  per-channel accept; at most one bit high per cycle.
- out_valid  output  1  output register holds a beat.
- out_data  output  WIDTH  registered data of the held beat.
- out_sel  output  SELW  index of the channel that supplied the held beat.
- out_ready  input  1  downstream accepts the held beat this cycle.

Behaviour:
- Reset: synchronous, active-high. Next edge with reset=1 sets out_valid=0, out_data=0, out_sel=0, rr pointer ptr=0. in_ready is combinational and is therefore 0 for all channels, because the grant is suppressed while reset=1.
- Reset mid-operation discards the held beat with no handshake.
- Transfer rules:
  - Input transfer on channel i: in_valid[i] & in_ready[i] at a rising edge.
  - Output transfer: out_valid & out_ready at a rising edge.
- can_accept = ~out_valid | out_ready (combinational). The register is refilled in the same cycle it drains.
- Grant (combinational): search channels ptr, ptr+1, ..., ptr+N-1 (mod N). The first with in_valid high is grant. gvalid = any in_valid.
- in_ready[grant] = gvalid & can_accept & ~reset. All other in_ready bits are 0.
- Input transfer at an edge:
  - out_data <= channel grant data.
  - out_sel <= grant.
  - out_valid <= 1.
  - ptr <= (grant+1) mod N, wrapping from N-1 to 0.
- Output transfer with no input transfer: out_valid <= 0. out_data and out_sel hold their last values.
- Neither transfer: all state holds, including ptr. A stalled output does not change the pointer.
- Latency: accepted beat appears on out_* the cycle after the accepting edge (1 cycle). Back-to-back beats every cycle while out_ready=1.
- Fairness: with all N channels continuously valid, grants rotate 0,1,...,N-1,0,... No channel waits more than N-1 grants.
- A single active channel is granted every cycle.
- A channel dropping in_valid without a transfer is legal. It is simply not granted; no error.
- out_data and out_sel are don't-care when out_valid=0, but are never X after reset.
- No combinational path from in_data to out_data.
- Combinational paths exist from in_valid and out_ready to in_ready only.

Optional Feature:
- Macro: RR_ARB_MUX_LOCK_EN.
- Defined:
  - Adds input port in_lock, width N, placed after in_data.
  - When a transfer on channel g has in_lock[g]=1, ptr <= g instead of g+1. Channel g keeps top priority for the next grant, so a burst is not interleaved while it stays valid.
  - A transfer with in_lock[g]=0 releases the lock (ptr <= g+1).
  - Reset clears any lock.
- Not defined: no in_lock port; ptr always advances as above.

Test Plan:
- Reset then idle: assert reset 2 cycles with in_valid=4'b1111 -> out_valid=0, out_data=0, out_sel=0, in_ready=0 during reset. First grant after release is channel 0.
- Full rotation, N=4, WIDTH=32, out_ready=1, all valid, channel i data=32'hA0+i -> out_sel sequence 0,1,2,3,0. out_data 0xA0,0xA1,0xA2,0xA3,0xA0, one per cycle, first beat 1 cycle after accept.
- Skip and wrap: ptr=3, in_valid=4'b0101 -> grant 0, then ptr=1. Next grant 2, then ptr=3.
- Backpressure: hold out_ready=0 for 3 cycles with out_valid=1, channel 1 valid -> in_ready=0, out_data/out_sel/ptr unchanged. Release out_ready -> same-cycle drain and refill from channel 1.
- Reset mid-operation: out_valid=1, out_ready=0, pulse reset -> out_valid=0 next cycle, held beat lost, ptr=0.
- With RR_ARB_MUX_LOCK_EN: all valid, channel 2 sends 3 beats with in_lock[2]=1,1,0 -> out_sel 2,2,2,3. Without the macro, the same stimulus gives 2,3,0,1.
